// File: rtl/spm_copy_engine_pkg.sv
// Shared SPM definitions: port widths, strobe/direction polarities and
// the copy-engine state type.
package spm_copy_engine_pkg;

    localparam int unsigned SPM_ADDR_W = 12;
    localparam int unsigned SPM_DATA_W = 32;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_CAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_FIN  = 3'd4
    } state_t;

endpackage

// File: rtl/spm_copy_engine.sv
// SPM block-copy engine: reads LEN words starting at SRC and writes them
// to DST through the shared mem-side SPM port, yielding to the pipeline
// whenever hold is high. All outputs are registered.
module spm_copy_engine
    import spm_copy_engine_pkg::*;
#(
    parameter int unsigned ADDR_W = SPM_ADDR_W,
    parameter int unsigned DATA_W = SPM_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] src_addr,
    input  logic [ADDR_W-1:0] dst_addr,
    input  logic [ADDR_W:0]   len,
    input  logic              hold,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] spm_addr,
    output logic              spm_as_,
    output logic              spm_rw,
    output logic [DATA_W-1:0] spm_wr_data,
    input  logic [DATA_W-1:0] spm_rd_data
);

    localparam logic [ADDR_W:0] LEN_MAX = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

    state_t            state, state_d;
    logic [ADDR_W-1:0] src_q, src_d;
    logic [ADDR_W-1:0] dst_q, dst_d;
    logic [ADDR_W:0]   len_q, len_d;
    logic [ADDR_W:0]   cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              busy_d, done_d, as_d, rw_d;
    logic [ADDR_W-1:0] addr_d;
    logic [DATA_W-1:0] wdata_d;
    logic [ADDR_W:0]   len_sat;
    logic [ADDR_W:0]   cnt_inc;

    assign len_sat = (len > LEN_MAX) ? LEN_MAX : len;
    assign cnt_inc = cnt_q + CNT_ONE;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state and next values of every registered output / datapath reg.
    // A len=0 request enters FIN with done still low, so FIN raises done on
    // its own and leaves the cycle after; a normal copy raises done on the
    // transition into FIN, so FIN sees done high and leaves at once.
    always_comb begin
        state_d = state;
        busy_d  = busy;
        done_d  = 1'b0;
        as_d    = DISABLE_;
        rw_d    = spm_rw;
        addr_d  = spm_addr;
        wdata_d = spm_wr_data;
        src_d   = src_q;
        dst_d   = dst_q;
        len_d   = len_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    busy_d = 1'b1;
                    if (len_sat != '0) begin
                        src_d   = src_addr;
                        dst_d   = dst_addr;
                        len_d   = len_sat;
                        cnt_d   = '0;
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_FIN;
                    end
                end
            end
            ST_RD: begin
                if (!hold) begin
                    as_d    = ENABLE_;
                    rw_d    = READ;
                    addr_d  = src_q + cnt_q[ADDR_W-1:0];
                    state_d = ST_CAP;
                end
            end
            ST_CAP: begin
                data_d  = spm_rd_data;
                state_d = ST_WR;
            end
            ST_WR: begin
                if (!hold) begin
                    as_d    = ENABLE_;
                    rw_d    = WRITE;
                    addr_d  = dst_q + cnt_q[ADDR_W-1:0];
                    wdata_d = data_q;
                    cnt_d   = cnt_inc;
                    if (cnt_inc == len_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_FIN;
                    end else begin
                        state_d = ST_RD;
                    end
                end
            end
            ST_FIN: begin
                if (done) begin
                    state_d = ST_IDLE;
                end else begin
                    done_d = 1'b1;
                    busy_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Output and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy        <= 1'b0;
            done        <= 1'b0;
            spm_as_     <= DISABLE_;
            spm_rw      <= READ;
            spm_addr    <= '0;
            spm_wr_data <= '0;
            src_q       <= '0;
            dst_q       <= '0;
            len_q       <= '0;
            cnt_q       <= '0;
            data_q      <= '0;
        end else begin
            busy        <= busy_d;
            done        <= done_d;
            spm_as_     <= as_d;
            spm_rw      <= rw_d;
            spm_addr    <= addr_d;
            spm_wr_data <= wdata_d;
            src_q       <= src_d;
            dst_q       <= dst_d;
            len_q       <= len_d;
            cnt_q       <= cnt_d;
            data_q      <= data_d;
        end
    end

endmodule
